// File: rtl/axis_perf_mon_pkg.sv
// Shared types and arithmetic helpers for the AXI-Stream performance monitor.
// Helpers work on 64-bit values with an explicit width so any counter size can share them.
package axis_perf_mon_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StRun   = 2'd2,
    StDone  = 2'd3
  } mon_state_e;

  localparam int unsigned MaxKeepWidth = 1024;
  localparam int unsigned MaxCntWidth  = 64;

  // Flag portion of a readout snapshot; counter fields follow the configured widths.
  typedef struct packed {
    logic valid;
    logic err;
    logic sat;
  } rd_flags_t;

  function automatic int unsigned popcount(input logic [MaxKeepWidth-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MaxKeepWidth; i++) begin
      n += {31'd0, v[i]};
    end
    return n;
  endfunction

  function automatic logic [MaxCntWidth-1:0] sat_add(input logic [MaxCntWidth-1:0] a,
                                                     input logic [MaxCntWidth-1:0] b,
                                                     input int unsigned w);
    logic [MaxCntWidth-1:0] max_val;
    max_val = (w >= MaxCntWidth) ? '1 : ((64'd1 << w) - 64'd1);
    if (b > max_val - a) begin
      return max_val;
    end
    return a + b;
  endfunction

  function automatic logic [MaxCntWidth-1:0] sat_inc(input logic [MaxCntWidth-1:0] a,
                                                     input int unsigned w);
    return sat_add(a, 64'd1, w);
  endfunction

endpackage

// File: rtl/axis_perf_mon_channel.sv
// One monitored stream: IDLE/ARMED/RUN/DONE control FSM plus its saturating counter set.
// Purely observes the tap signals; nothing here feeds back into the link.
module axis_perf_mon_channel
  import axis_perf_mon_pkg::*;
#(
  parameter int unsigned KEEP_WIDTH     = 64,
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned BYTE_CNT_WIDTH = 48
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tvalid,
  input  logic                      tready,
  input  logic                      tlast,
  input  logic [KEEP_WIDTH-1:0]     tkeep,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      clear,
  input  logic [CNT_WIDTH-1:0]      window_cycles,
  output logic                      armed,
  output logic                      running,
  output logic                      done,
  output logic [CNT_WIDTH-1:0]      cycle_cnt,
  output logic [CNT_WIDTH-1:0]      beat_cnt,
  output logic [CNT_WIDTH-1:0]      pkt_cnt,
  output logic [BYTE_CNT_WIDTH-1:0] byte_cnt,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic                      saturated
);

  mon_state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]      cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0]      beat_q, beat_d;
  logic [CNT_WIDTH-1:0]      pkt_q, pkt_d;
  logic [CNT_WIDTH-1:0]      stall_q, stall_d;
  logic [BYTE_CNT_WIDTH-1:0] byte_q, byte_d;
  logic [CNT_WIDTH-1:0]      window_q, window_d;
  logic                      sat_q, sat_d;

  logic                    beat, stall, accumulate, zero_cnt;
  logic [MaxKeepWidth-1:0] keep_ext;
  int unsigned             keep_bytes;

  assign beat  = tvalid & tready;
  assign stall = tvalid & ~tready;

  always_comb begin
    keep_ext                 = '0;
    keep_ext[KEEP_WIDTH-1:0] = tkeep;
    keep_bytes               = popcount(keep_ext);
  end

  always_comb begin
    state_d    = state_q;
    cycle_d    = cycle_q;
    beat_d     = beat_q;
    pkt_d      = pkt_q;
    stall_d    = stall_q;
    byte_d     = byte_q;
    window_d   = window_q;
    sat_d      = sat_q;
    accumulate = 1'b0;
    zero_cnt   = 1'b0;

    // clear beats stop beats start
    if (clear) begin
      state_d  = StIdle;
      window_d = '0;
      zero_cnt = 1'b1;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start && !stop) begin
            state_d  = StArmed;
            window_d = window_cycles;
            zero_cnt = 1'b1;
          end
        end
        StArmed: begin
          if (stop) begin
            state_d = StIdle;
          end else if (beat) begin
            state_d    = StRun;
            accumulate = 1'b1;
          end
        end
        StRun: begin
          if (stop) begin
            state_d = StDone;
          end else begin
            accumulate = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (zero_cnt) begin
      cycle_d = '0;
      beat_d  = '0;
      pkt_d   = '0;
      stall_d = '0;
      byte_d  = '0;
      sat_d   = 1'b0;
    end

    if (accumulate) begin
      cycle_d = CNT_WIDTH'(sat_inc(64'(cycle_q), CNT_WIDTH));
      if (beat) begin
        beat_d = CNT_WIDTH'(sat_inc(64'(beat_q), CNT_WIDTH));
        byte_d = BYTE_CNT_WIDTH'(sat_add(64'(byte_q), 64'(keep_bytes), BYTE_CNT_WIDTH));
        if (tlast) begin
          pkt_d = CNT_WIDTH'(sat_inc(64'(pkt_q), CNT_WIDTH));
        end
      end
      if (stall) begin
        stall_d = CNT_WIDTH'(sat_inc(64'(stall_q), CNT_WIDTH));
      end
      // A counter sitting at all-ones counts as saturated; earlier hits are already sticky.
      sat_d = sat_q | (&cycle_d) | (&beat_d) | (&pkt_d) | (&stall_d) | (&byte_d);
      if (((window_q != '0) && (cycle_d == window_q)) || (&cycle_d)) begin
        state_d = StDone;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cycle_q  <= '0;
      beat_q   <= '0;
      pkt_q    <= '0;
      stall_q  <= '0;
      byte_q   <= '0;
      window_q <= '0;
      sat_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cycle_q  <= cycle_d;
      beat_q   <= beat_d;
      pkt_q    <= pkt_d;
      stall_q  <= stall_d;
      byte_q   <= byte_d;
      window_q <= window_d;
      sat_q    <= sat_d;
    end
  end

  assign armed     = (state_q == StArmed);
  assign running   = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign cycle_cnt = cycle_q;
  assign beat_cnt  = beat_q;
  assign pkt_cnt   = pkt_q;
  assign stall_cnt = stall_q;
  assign byte_cnt  = byte_q;
  assign saturated = sat_q;

endmodule

// File: rtl/axis_multi_perf_monitor.sv
// Passive multi-channel AXI-Stream throughput/latency monitor with a registered
// one-cycle readout snapshot of the selected channel.
module axis_multi_perf_monitor
  import axis_perf_mon_pkg::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned KEEP_WIDTH     = 64,
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned BYTE_CNT_WIDTH = 48,
  parameter int unsigned SEL_WIDTH      = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_CH-1:0]            mon_tvalid,
  input  logic [NUM_CH-1:0]            mon_tready,
  input  logic [NUM_CH-1:0]            mon_tlast,
  input  logic [NUM_CH*KEEP_WIDTH-1:0] mon_tkeep,
  input  logic [NUM_CH-1:0]            ctl_start,
  input  logic [NUM_CH-1:0]            ctl_stop,
  input  logic [NUM_CH-1:0]            ctl_clear,
  input  logic [CNT_WIDTH-1:0]         window_cycles,
  input  logic                         rd_req,
  input  logic [SEL_WIDTH-1:0]         rd_ch_sel,
  output logic                         rd_valid,
  output logic                         rd_err,
  output logic [CNT_WIDTH-1:0]         rd_cycle_cnt,
  output logic [CNT_WIDTH-1:0]         rd_beat_cnt,
  output logic [CNT_WIDTH-1:0]         rd_pkt_cnt,
  output logic [BYTE_CNT_WIDTH-1:0]    rd_byte_cnt,
  output logic [CNT_WIDTH-1:0]         rd_stall_cnt,
  output logic                         rd_saturated,
  output logic [NUM_CH-1:0]            ch_armed,
  output logic [NUM_CH-1:0]            ch_running,
  output logic [NUM_CH-1:0]            ch_done
);

  logic [CNT_WIDTH-1:0]      cyc_cnt   [NUM_CH];
  logic [CNT_WIDTH-1:0]      beat_cnt  [NUM_CH];
  logic [CNT_WIDTH-1:0]      pkt_cnt   [NUM_CH];
  logic [CNT_WIDTH-1:0]      stall_cnt [NUM_CH];
  logic [BYTE_CNT_WIDTH-1:0] byte_cnt  [NUM_CH];
  logic [NUM_CH-1:0]         sat;

  for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
    axis_perf_mon_channel #(
      .KEEP_WIDTH    (KEEP_WIDTH),
      .CNT_WIDTH     (CNT_WIDTH),
      .BYTE_CNT_WIDTH(BYTE_CNT_WIDTH)
    ) u_ch (
      .clk          (CLK),
      .rst          (RST),
      .tvalid       (mon_tvalid[g]),
      .tready       (mon_tready[g]),
      .tlast        (mon_tlast[g]),
      .tkeep        (mon_tkeep[g*KEEP_WIDTH +: KEEP_WIDTH]),
      .start        (ctl_start[g]),
      .stop         (ctl_stop[g]),
      .clear        (ctl_clear[g]),
      .window_cycles(window_cycles),
      .armed        (ch_armed[g]),
      .running      (ch_running[g]),
      .done         (ch_done[g]),
      .cycle_cnt    (cyc_cnt[g]),
      .beat_cnt     (beat_cnt[g]),
      .pkt_cnt      (pkt_cnt[g]),
      .byte_cnt     (byte_cnt[g]),
      .stall_cnt    (stall_cnt[g]),
      .saturated    (sat[g])
    );
  end

  rd_flags_t                 flags_d, flags_q;
  logic [CNT_WIDTH-1:0]      snap_cyc_d, snap_cyc_q;
  logic [CNT_WIDTH-1:0]      snap_beat_d, snap_beat_q;
  logic [CNT_WIDTH-1:0]      snap_pkt_d, snap_pkt_q;
  logic [CNT_WIDTH-1:0]      snap_stall_d, snap_stall_q;
  logic [BYTE_CNT_WIDTH-1:0] snap_byte_d, snap_byte_q;

  // Data fields stay zero unless a valid in-range channel is being read.
  always_comb begin
    flags_d       = '0;
    snap_cyc_d    = '0;
    snap_beat_d   = '0;
    snap_pkt_d    = '0;
    snap_stall_d  = '0;
    snap_byte_d   = '0;
    flags_d.valid = rd_req;
    if (rd_req) begin
      if (32'(rd_ch_sel) >= NUM_CH) begin
        flags_d.err = 1'b1;
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (rd_ch_sel == SEL_WIDTH'(i)) begin
            snap_cyc_d   = cyc_cnt[i];
            snap_beat_d  = beat_cnt[i];
            snap_pkt_d   = pkt_cnt[i];
            snap_stall_d = stall_cnt[i];
            snap_byte_d  = byte_cnt[i];
            flags_d.sat  = sat[i];
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      flags_q      <= '0;
      snap_cyc_q   <= '0;
      snap_beat_q  <= '0;
      snap_pkt_q   <= '0;
      snap_stall_q <= '0;
      snap_byte_q  <= '0;
    end else begin
      flags_q      <= flags_d;
      snap_cyc_q   <= snap_cyc_d;
      snap_beat_q  <= snap_beat_d;
      snap_pkt_q   <= snap_pkt_d;
      snap_stall_q <= snap_stall_d;
      snap_byte_q  <= snap_byte_d;
    end
  end

  assign rd_valid     = flags_q.valid;
  assign rd_err       = flags_q.err;
  assign rd_saturated = flags_q.sat;
  assign rd_cycle_cnt = snap_cyc_q;
  assign rd_beat_cnt  = snap_beat_q;
  assign rd_pkt_cnt   = snap_pkt_q;
  assign rd_byte_cnt  = snap_byte_q;
  assign rd_stall_cnt = snap_stall_q;

endmodule

// File: tb/tb_axis_multi_perf_monitor.sv
// Self-checking bench: a default 4-channel monitor plus a 1-channel, 4-bit-counter build,
// compared against a transaction-level reference model of the measurement rules.
module tb_axis_multi_perf_monitor;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  // main instance
  logic [3:0]   mon_tvalid, mon_tready, mon_tlast, ctl_start, ctl_stop, ctl_clear;
  logic [255:0] mon_tkeep;
  logic [31:0]  window_cycles;
  logic         rd_req;
  logic [3:0]   rd_ch_sel;
  logic         rd_valid, rd_err, rd_saturated;
  logic [31:0]  rd_cycle_cnt, rd_beat_cnt, rd_pkt_cnt, rd_stall_cnt;
  logic [47:0]  rd_byte_cnt;
  logic [3:0]   ch_armed, ch_running, ch_done;

  // small-counter instance
  logic       s_tvalid, s_tready, s_tlast, s_start, s_stop, s_clear;
  logic [7:0] s_tkeep;
  logic [3:0] s_window;
  logic       s_rd_req, s_rd_ch_sel;
  logic       s_rd_valid, s_rd_err, s_rd_saturated;
  logic [3:0] s_rd_cycle_cnt, s_rd_beat_cnt, s_rd_pkt_cnt, s_rd_stall_cnt;
  logic [7:0] s_rd_byte_cnt;
  logic       s_ch_armed, s_ch_running, s_ch_done;

  axis_multi_perf_monitor dut (
    .CLK(CLK), .RST(RST), .mon_tvalid(mon_tvalid), .mon_tready(mon_tready),
    .mon_tlast(mon_tlast), .mon_tkeep(mon_tkeep), .ctl_start(ctl_start), .ctl_stop(ctl_stop),
    .ctl_clear(ctl_clear), .window_cycles(window_cycles), .rd_req(rd_req),
    .rd_ch_sel(rd_ch_sel), .rd_valid(rd_valid), .rd_err(rd_err), .rd_cycle_cnt(rd_cycle_cnt),
    .rd_beat_cnt(rd_beat_cnt), .rd_pkt_cnt(rd_pkt_cnt), .rd_byte_cnt(rd_byte_cnt),
    .rd_stall_cnt(rd_stall_cnt), .rd_saturated(rd_saturated), .ch_armed(ch_armed),
    .ch_running(ch_running), .ch_done(ch_done)
  );

  axis_multi_perf_monitor #(
    .NUM_CH(1), .KEEP_WIDTH(8), .CNT_WIDTH(4), .BYTE_CNT_WIDTH(8), .SEL_WIDTH(1)
  ) dut_s (
    .CLK(CLK), .RST(RST), .mon_tvalid(s_tvalid), .mon_tready(s_tready),
    .mon_tlast(s_tlast), .mon_tkeep(s_tkeep), .ctl_start(s_start), .ctl_stop(s_stop),
    .ctl_clear(s_clear), .window_cycles(s_window), .rd_req(s_rd_req),
    .rd_ch_sel(s_rd_ch_sel), .rd_valid(s_rd_valid), .rd_err(s_rd_err),
    .rd_cycle_cnt(s_rd_cycle_cnt), .rd_beat_cnt(s_rd_beat_cnt), .rd_pkt_cnt(s_rd_pkt_cnt),
    .rd_byte_cnt(s_rd_byte_cnt), .rd_stall_cnt(s_rd_stall_cnt),
    .rd_saturated(s_rd_saturated), .ch_armed(s_ch_armed), .ch_running(s_ch_running),
    .ch_done(s_ch_done)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: index 0..3 = main channels, 4 = small instance. States 0..3 = IDLE..DONE.
  int              m_state [5];
  longint unsigned m_cyc [5], m_beat [5], m_pkt [5], m_byte [5], m_stall [5], m_win [5];
  bit              m_sat [5];

  bit              exp_valid, exp_err, exp_sat, s_exp_valid, s_exp_err, s_exp_sat;
  longint unsigned exp_cyc, exp_beat, exp_pkt, exp_byte, exp_stall;
  longint unsigned s_exp_cyc, s_exp_beat, s_exp_pkt, s_exp_byte, s_exp_stall;

  function automatic longint unsigned cap(longint unsigned x, longint unsigned m);
    return (x > m) ? m : x;
  endfunction

  task automatic model_zero(int k);
    m_cyc[k] = 0; m_beat[k] = 0; m_pkt[k] = 0; m_byte[k] = 0; m_stall[k] = 0; m_sat[k] = 0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 5; k++) begin
      m_state[k] = 0; m_win[k] = 0; model_zero(k);
    end
  endtask

  task automatic model_step(int k, bit v, bit r, bit l, int ones, bit st, bit sp, bit cl,
                            longint unsigned win, longint unsigned cmax,
                            longint unsigned bmax);
    bit counted = 0;
    if (cl) begin
      m_state[k] = 0; m_win[k] = 0; model_zero(k);
    end else if (m_state[k] == 0 || m_state[k] == 3) begin
      if (st && !sp) begin m_state[k] = 1; m_win[k] = win; model_zero(k); end
    end else if (m_state[k] == 1) begin
      if (sp) m_state[k] = 0;
      else if (v && r) begin m_state[k] = 2; counted = 1; end
    end else begin
      if (sp) m_state[k] = 3;
      else counted = 1;
    end
    if (counted) begin
      m_cyc[k] = cap(m_cyc[k] + 1, cmax);
      if (v && r) begin
        m_beat[k] = cap(m_beat[k] + 1, cmax);
        m_byte[k] = cap(m_byte[k] + longint'(ones), bmax);
        if (l) m_pkt[k] = cap(m_pkt[k] + 1, cmax);
      end
      if (v && !r) m_stall[k] = cap(m_stall[k] + 1, cmax);
      if (m_cyc[k] == cmax || m_beat[k] == cmax || m_pkt[k] == cmax ||
          m_stall[k] == cmax || m_byte[k] == bmax) m_sat[k] = 1;
      if ((m_win[k] != 0 && m_cyc[k] == m_win[k]) || m_cyc[k] == cmax) m_state[k] = 3;
    end
  endtask

  // Capture expected snapshots, advance the model with the current inputs, then one clock.
  task automatic tick();
    int k;
    exp_valid = rd_req; exp_err = 0; exp_sat = 0;
    exp_cyc = 0; exp_beat = 0; exp_pkt = 0; exp_byte = 0; exp_stall = 0;
    if (rd_req) begin
      if (rd_ch_sel >= 4) exp_err = 1;
      else begin
        k = int'(rd_ch_sel);
        exp_cyc = m_cyc[k]; exp_beat = m_beat[k]; exp_pkt = m_pkt[k];
        exp_byte = m_byte[k]; exp_stall = m_stall[k]; exp_sat = m_sat[k];
      end
    end
    s_exp_valid = s_rd_req; s_exp_err = 0; s_exp_sat = 0;
    s_exp_cyc = 0; s_exp_beat = 0; s_exp_pkt = 0; s_exp_byte = 0; s_exp_stall = 0;
    if (s_rd_req) begin
      if (s_rd_ch_sel != 1'b0) s_exp_err = 1;
      else begin
        s_exp_cyc = m_cyc[4]; s_exp_beat = m_beat[4]; s_exp_pkt = m_pkt[4];
        s_exp_byte = m_byte[4]; s_exp_stall = m_stall[4]; s_exp_sat = m_sat[4];
      end
    end
    for (int c = 0; c < 4; c++) begin
      model_step(c, mon_tvalid[c], mon_tready[c], mon_tlast[c],
                 $countones(mon_tkeep[c*64 +: 64]), ctl_start[c], ctl_stop[c], ctl_clear[c],
                 64'(window_cycles), 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF);
    end
    model_step(4, s_tvalid, s_tready, s_tlast, $countones(s_tkeep), s_start, s_stop, s_clear,
               64'(s_window), 64'd15, 64'd255);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    mon_tvalid = '0; mon_tready = '0; mon_tlast = '0; mon_tkeep = '0;
    ctl_start = '0; ctl_stop = '0; ctl_clear = '0; window_cycles = '0;
    rd_req = 0; rd_ch_sel = '0;
    s_tvalid = 0; s_tready = 0; s_tlast = 0; s_tkeep = '0; s_start = 0; s_stop = 0;
    s_clear = 0; s_window = '0; s_rd_req = 0; s_rd_ch_sel = 0;
  endtask

  task automatic read_main(logic [3:0] sel);
    rd_req = 1; rd_ch_sel = sel;
    tick();
    rd_req = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    RST = 1;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({rd_valid, rd_err, rd_saturated, ch_armed, ch_running, ch_done} !== 15'd0 ||
        {rd_cycle_cnt, rd_beat_cnt, rd_pkt_cnt, rd_stall_cnt, rd_byte_cnt} !== 176'd0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b err=%b st=%h/%h/%h cyc=%0d want all 0",
               rd_valid, rd_err, ch_armed, ch_running, ch_done, rd_cycle_cnt);
    end
    checks++;
    if ({s_rd_valid, s_rd_err, s_ch_armed, s_ch_running, s_ch_done, s_rd_beat_cnt} !== 9'd0) begin
      errors++;
      $display("FAIL reset_small: valid=%b beat=%0d want 0", s_rd_valid, s_rd_beat_cnt);
    end
    RST = 0;
    model_reset();
    tick();
    read_main(4'd0);
    checks++;
    if (rd_valid !== 1'b1 || rd_err !== 1'b0 || rd_cycle_cnt !== 0 || rd_beat_cnt !== 0 ||
        rd_byte_cnt !== 0 || rd_saturated !== 0) begin
      errors++;
      $display("FAIL reset_read: valid=%b err=%b cyc=%0d beat=%0d want valid=1 err=0 zeros",
               rd_valid, rd_err, rd_cycle_cnt, rd_beat_cnt);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_valid_pulse: got %b want 0", rd_valid);
    end
  endtask

  task automatic test_basic_run();
    window_cycles = 0; ctl_start[0] = 1;
    tick();
    ctl_start[0] = 0;
    checks++;
    if (ch_armed[0] !== 1'b1) begin
      errors++; $display("FAIL ch0_armed: got %b want 1", ch_armed[0]);
    end
    repeat (3) tick();
    for (int b = 0; b < 4; b++) begin
      mon_tvalid[0] = 1; mon_tready[0] = 1; mon_tkeep[63:0] = '1; mon_tlast[0] = (b == 3);
      tick();
    end
    mon_tready[0] = 0; mon_tlast[0] = 0;
    repeat (2) tick();
    mon_tvalid[0] = 0; ctl_stop[0] = 1;
    tick();
    ctl_stop[0] = 0;
    checks++;
    if (ch_done[0] !== 1'b1 || ch_running[0] !== 1'b0) begin
      errors++; $display("FAIL ch0_done: done=%b run=%b want 1/0", ch_done[0], ch_running[0]);
    end
    read_main(4'd0);
    checks++;
    if (rd_cycle_cnt !== 6 || rd_beat_cnt !== 4 || rd_pkt_cnt !== 1 || rd_byte_cnt !== 256 ||
        rd_stall_cnt !== 2 || rd_err !== 0 || rd_valid !== 1) begin
      errors++;
      $display("FAIL basic_counts: cyc=%0d beat=%0d pkt=%0d byte=%0d stall=%0d want 6/4/1/256/2",
               rd_cycle_cnt, rd_beat_cnt, rd_pkt_cnt, rd_byte_cnt, rd_stall_cnt);
    end
  endtask

  task automatic test_window();
    window_cycles = 10; ctl_start[1] = 1;
    tick();
    ctl_start[1] = 0; window_cycles = 0;
    mon_tvalid[1] = 1; mon_tready[1] = 1; mon_tkeep[127:64] = 64'h0F;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 9) begin
        checks++;
        if (ch_running[1] !== 1'b1) begin
          errors++; $display("FAIL window_early: running=%b want 1 after 9", ch_running[1]);
        end
      end
    end
    checks++;
    if (ch_done[1] !== 1'b1) begin
      errors++; $display("FAIL window_done: done=%b want 1 after 10", ch_done[1]);
    end
    repeat (3) tick();
    mon_tvalid[1] = 0;
    read_main(4'd1);
    checks++;
    if (rd_cycle_cnt !== 10 || rd_beat_cnt !== 10 || rd_byte_cnt !== 40 || rd_pkt_cnt !== 0 ||
        rd_stall_cnt !== 0) begin
      errors++;
      $display("FAIL window_counts: cyc=%0d beat=%0d byte=%0d want 10/10/40",
               rd_cycle_cnt, rd_beat_cnt, rd_byte_cnt);
    end
  endtask

  task automatic test_saturation();
    s_start = 1;
    tick();
    s_start = 0; s_tvalid = 1; s_tready = 1; s_tkeep = 8'hFF;
    repeat (14) tick();
    checks++;
    if (s_ch_running !== 1'b1) begin
      errors++; $display("FAIL sat_running: got %b want 1 at cycle 14", s_ch_running);
    end
    tick();
    checks++;
    if (s_ch_done !== 1'b1) begin
      errors++; $display("FAIL sat_done: got %b want 1 at cycle 15", s_ch_done);
    end
    repeat (2) tick();
    s_tvalid = 0; s_rd_req = 1;
    tick();
    s_rd_req = 0;
    checks++;
    if (s_rd_beat_cnt !== 15 || s_rd_cycle_cnt !== 15 || s_rd_byte_cnt !== 120 ||
        s_rd_saturated !== 1'b1 || s_rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL sat_counts: beat=%0d cyc=%0d byte=%0d sat=%b want 15/15/120/1",
               s_rd_beat_cnt, s_rd_cycle_cnt, s_rd_byte_cnt, s_rd_saturated);
    end
    s_start = 1;
    tick();
    s_start = 0; s_rd_req = 1;
    tick();
    s_rd_req = 0;
    checks++;
    if (s_rd_saturated !== 1'b0 || s_rd_beat_cnt !== 0 || s_ch_armed !== 1'b1) begin
      errors++;
      $display("FAIL sat_restart: sat=%b beat=%0d armed=%b want 0/0/1",
               s_rd_saturated, s_rd_beat_cnt, s_ch_armed);
    end
  endtask

  task automatic test_ctrl_priority();
    ctl_start[3] = 1;
    tick();
    ctl_start[3] = 0; mon_tvalid[3] = 1; mon_tready[3] = 1; mon_tkeep[255:192] = 64'hFF;
    tick();
    mon_tvalid[3] = 0;
    ctl_clear[3] = 1; ctl_stop[3] = 1; ctl_start[3] = 1;
    tick();
    ctl_clear[3] = 0; ctl_stop[3] = 0; ctl_start[3] = 0;
    read_main(4'd3);
    checks++;
    if ({ch_armed[3], ch_running[3], ch_done[3]} !== 3'b000 || rd_cycle_cnt !== 0 ||
        rd_beat_cnt !== 0 || rd_byte_cnt !== 0) begin
      errors++;
      $display("FAIL clear_prio: st=%b%b%b cyc=%0d beat=%0d want idle zeros",
               ch_armed[3], ch_running[3], ch_done[3], rd_cycle_cnt, rd_beat_cnt);
    end
    ctl_start[3] = 1;
    tick();
    ctl_start[3] = 0; mon_tvalid[3] = 1; mon_tready[3] = 1;
    repeat (3) tick();
    mon_tvalid[3] = 0; ctl_stop[3] = 1; ctl_start[3] = 1;
    tick();
    ctl_stop[3] = 0; ctl_start[3] = 0;
    read_main(4'd3);
    checks++;
    if (ch_done[3] !== 1'b1 || rd_beat_cnt !== 3 || rd_cycle_cnt !== 3 || rd_byte_cnt !== 24) begin
      errors++;
      $display("FAIL stop_prio: done=%b beat=%0d cyc=%0d byte=%0d want 1/3/3/24",
               ch_done[3], rd_beat_cnt, rd_cycle_cnt, rd_byte_cnt);
    end
    for (int s = 4; s < 16; s += 11) begin
      read_main(4'(s));
      checks++;
      if (rd_valid !== 1'b1 || rd_err !== 1'b1 || rd_cycle_cnt !== 0 || rd_beat_cnt !== 0 ||
          rd_byte_cnt !== 0 || rd_saturated !== 0) begin
        errors++;
        $display("FAIL bad_sel%0d: valid=%b err=%b cyc=%0d want 1/1/0", s, rd_valid, rd_err,
                 rd_cycle_cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] want_a, want_r, want_d;
    window_cycles = 40; ctl_start[0] = 1;
    tick();
    ctl_start[0] = 0; window_cycles = 0; ctl_start[2] = 1;
    tick();
    ctl_start[2] = 0;
    for (int i = 0; i < 80; i++) begin
      mon_tvalid[0] = 1'($urandom_range(0, 1)); mon_tready[0] = 1'($urandom_range(0, 1));
      mon_tlast[0]  = 1'($urandom_range(0, 1)); mon_tkeep[63:0] = {$urandom, $urandom};
      mon_tvalid[2] = 1'($urandom_range(0, 1)); mon_tready[2] = 1'($urandom_range(0, 1));
      mon_tlast[2]  = 1'($urandom_range(0, 1)); mon_tkeep[191:128] = {$urandom, $urandom};
      ctl_stop[2] = (i == 60);
      rd_req = 1; rd_ch_sel = (i % 2 == 0) ? 4'd0 : 4'd2;
      tick();
      checks++;
      if (rd_valid !== exp_valid || rd_err !== exp_err || 64'(rd_cycle_cnt) !== exp_cyc ||
          64'(rd_beat_cnt) !== exp_beat || 64'(rd_pkt_cnt) !== exp_pkt ||
          64'(rd_byte_cnt) !== exp_byte || 64'(rd_stall_cnt) !== exp_stall ||
          rd_saturated !== exp_sat) begin
        errors++;
        $display("FAIL b2b_read%0d: cyc=%0d beat=%0d pkt=%0d byte=%0d stall=%0d want %0d/%0d/%0d/%0d/%0d",
                 i, rd_cycle_cnt, rd_beat_cnt, rd_pkt_cnt, rd_byte_cnt, rd_stall_cnt,
                 exp_cyc, exp_beat, exp_pkt, exp_byte, exp_stall);
      end
      for (int c = 0; c < 4; c++) begin
        want_a[c] = (m_state[c] == 1); want_r[c] = (m_state[c] == 2);
        want_d[c] = (m_state[c] == 3);
      end
      checks++;
      if (ch_armed !== want_a || ch_running !== want_r || ch_done !== want_d) begin
        errors++;
        $display("FAIL b2b_status%0d: a/r/d=%h/%h/%h want %h/%h/%h", i, ch_armed, ch_running,
                 ch_done, want_a, want_r, want_d);
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_window();
    test_saturation();
    test_ctrl_priority();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_multi_perf_monitor.md
Name: axis_multi_perf_monitor

Overview:
Passive, parametrised throughput/latency monitor that taps NUM_CH AXI-Stream links (XDMA H2C/C2H, UDP TX/RX) without altering them. It replaces the fixed two-channel, ILA-probed counters with per-channel windowed measurement: cycles, beats, packets, bytes and back-pressure stalls. Results are read through a one-cycle snapshot port driven by host-side control logic on the XDMA clock domain.

Parameters:
NUM_CH, 4, number of monitored streams (1..16)
KEEP_WIDTH, 64, tkeep width; bytes per beat
CNT_WIDTH, 32, width of cycle/beat/packet/stall counters and window_cycles
BYTE_CNT_WIDTH, 48, width of byte counter
SEL_WIDTH, 4, width of rd_ch_sel (must satisfy 2^SEL_WIDTH >= NUM_CH)

Ports:
CLK  in  1  monitor clock; all monitored streams are synchronous to it
RST  in  1  asynchronous, active-high reset
mon_tvalid  in  NUM_CH  per-channel tvalid tap
mon_tready  in  NUM_CH  per-channel tready tap
mon_tlast  in  NUM_CH  per-channel tlast tap
mon_tkeep  in  NUM_CH*KEEP_WIDTH  per-channel tkeep; channel i occupies bits [i*KEEP_WIDTH +: KEEP_WIDTH]
ctl_start  in  NUM_CH  per-channel pulse: arm measurement
ctl_stop  in  NUM_CH  per-channel pulse: end measurement
ctl_clear  in  NUM_CH  per-channel pulse: return to IDLE, zero counters
window_cycles  in  CNT_WIDTH  measurement window length in cycles; 0 = unbounded; sampled on arm
rd_req  in  1  readout request
rd_ch_sel  in  SEL_WIDTH  channel to read
rd_valid  out  1  snapshot valid (one-cycle pulse)
rd_err  out  1  rd_ch_sel >= NUM_CH (qualified by rd_valid)
rd_cycle_cnt  out  CNT_WIDTH  snapshot cycle count
rd_beat_cnt  out  CNT_WIDTH  snapshot beat count
rd_pkt_cnt  out  CNT_WIDTH  snapshot packet count
rd_byte_cnt  out  BYTE_CNT_WIDTH  snapshot byte count
rd_stall_cnt  out  CNT_WIDTH  snapshot stall count
rd_saturated  out  1  snapshot sticky saturation flag
ch_armed  out  NUM_CH  channel in ARMED
ch_running  out  NUM_CH  channel in RUN
ch_done  out  NUM_CH  channel in DONE

Behaviour:
- Reset: all outputs 0; every channel IDLE; all counters, window registers and sat flags 0.
- Beat on channel i = mon_tvalid[i] & mon_tready[i]; stall = mon_tvalid[i] & ~mon_tready[i].
- Per-channel FSM, states IDLE, ARMED, RUN, DONE; control priority clear > stop > start in the same cycle.
  - clear (any state) -> IDLE, counters and sat zeroed next cycle.
  - IDLE/DONE + start -> ARMED; counters zeroed; window_cycles latched into the per-channel window register.
  - ARMED + beat -> RUN; that cycle counts: cycle=1, beat=1, bytes=popcount(tkeep), pkt+1 if tlast.
  - ARMED + stop -> IDLE (no data captured).
  - RUN: each cycle cycle+1; beat -> beat+1, bytes += popcount(tkeep), pkt+1 if tlast; stall -> stall+1.
  - RUN -> DONE on stop (stop cycle is NOT counted), on cycle count reaching window (the final cycle IS counted), or on cycle counter saturation.
  - RUN + start with no stop: ignored. DONE holds counts until start or clear.
- Arithmetic: popcount over KEEP_WIDTH bits, zero-extended to BYTE_CNT_WIDTH. Every counter saturates at all-ones and never wraps; any saturation sets the sticky per-channel sat flag, cleared only by start, clear or RST.
- Readout: rd_req sampled at cycle N; at N+1, rd_valid=1 with registered snapshot of the selected channel's values as of cycle N. Reading is non-destructive, is legal in any state and back-to-back every cycle. Out-of-range sel: rd_err=1, all data fields 0.
- The monitor never drives tready/tvalid; it has zero effect on the monitored links.
- Reset asserted mid-measurement: immediate return to reset state; no partial results retained.

Decomposition:
- Package axis_perf_mon_pkg: state encoding (IDLE=0, ARMED=1, RUN=2, DONE=3), popcount function, saturating-increment and saturating-add functions, snapshot record layout.
- Sub-module axis_perf_mon_channel: one FSM plus counter set, instantiated NUM_CH times in a generate loop. The top level contains only the readout mux/snapshot register and status concatenation.

Test Plan:
- Reset then idle: all outputs 0; a rd_req for ch0 returns rd_valid at N+1 with all counts 0 and rd_err=0.
- ch0 start, window=0: 3 idle cycles, then 4 full beats (tkeep all ones) with tlast on the 4th, 2 stall cycles, then stop -> cycle=6, beat=4, pkt=1, bytes=256, stall=2, ch_done[0]=1.
- ch1 window=10, continuous beats with tkeep=0x0F: auto-DONE after 10 counted cycles -> beat=10, bytes=40; beats after DONE leave the counts unchanged.
- CNT_WIDTH=4 build, continuous beats -> beat count saturates at 15, rd_saturated=1, DONE on cycle-count saturation; the following start clears sat.
- Same-cycle clear+stop+start on a RUN channel -> IDLE with zero counts. stop+start on a RUN channel -> DONE. rd_ch_sel=NUM_CH -> rd_err=1, data fields 0.
- Independent channels: ch0 and ch2 run overlapping windows with distinct traffic; back-to-back reads alternating between them return correct per-channel snapshots every cycle.
